// File: rtl/tinytpu_mmu_serial_if.sv
// ============================================================================
// tinytpu_mmu_serial_if
// Serial load / compute-request / result-stream signal bundle for the MMU core.
// Rev 1.0
// ============================================================================
`default_nettype none

interface tinytpu_mmu_serial_if;
    logic data_in_x;
    logic data_in_y;
    logic load_en;
    logic init;
    logic acc_mode;
    logic data_out_z;
    logic tx_ready;
    logic tx_last;
    logic busy;
    logic loaded;

    modport master (
        output data_in_x, data_in_y, load_en, init, acc_mode,
        input  data_out_z, tx_ready, tx_last, busy, loaded
    );

    modport slave (
        input  data_in_x, data_in_y, load_en, init, acc_mode,
        output data_out_z, tx_ready, tx_last, busy, loaded
    );
endinterface

`default_nettype wire

// File: rtl/tinytpu_mmu_serial.sv
// ============================================================================
// tinytpu_mmu_serial
// Bit-serial N x N matrix multiply (Z = X*Y or Z += X*Y) with one MAC per cycle.
// Rev 1.0
// ============================================================================
`default_nettype none

module tinytpu_mmu_serial #(
    parameter int D_W    = 8,
    parameter int N      = 2,
    parameter int ACC_W  = 2*D_W + $clog2(N) + 1,
    parameter int SIGNED = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    tinytpu_mmu_serial_if.slave bus
);

    localparam int XV_W = N*N*D_W;
    localparam int ZV_W = N*N*ACC_W;
    localparam int XI_W = (XV_W > 1) ? $clog2(XV_W) : 1;
    localparam int ZI_W = (ZV_W > 1) ? $clog2(ZV_W) : 1;
    localparam int IX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IX_W-1:0] IDX_LAST = IX_W'(N-1);
    localparam logic [XI_W-1:0] LD_LAST  = XI_W'(XV_W-1);
    localparam logic [ZI_W-1:0] TX_LAST  = ZI_W'(ZV_W-1);
    localparam logic            SIGN_EXT = (SIGNED != 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_TX      = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [XV_W-1:0]  x_q, y_q;
    logic [ZV_W-1:0]  z_q;
    logic [ACC_W-1:0] acc_q;
    logic [IX_W-1:0]  i_q, j_q, k_q;
    logic [XI_W-1:0]  ld_cnt_q;
    logic [ZI_W-1:0]  tx_cnt_q;
    logic             loaded_q, acc_mode_q;
    logic             dout_q, tx_ready_q, tx_last_q;

    logic             w_start, w_load, w_mac_last, w_tx_done;
    logic [XI_W-1:0]  w_xsel, w_ysel;
    logic [ZI_W-1:0]  w_zsel, w_tx_next;
    logic [D_W-1:0]   w_xe, w_ye;
    logic [ACC_W-1:0] w_xx, w_yx, w_prod, w_zold, w_base, w_sum;

    assign w_start    = (state_q == S_IDLE) && bus.init && loaded_q;
    assign w_load     = (state_q == S_IDLE) && bus.load_en && !loaded_q;
    assign w_mac_last = (state_q == S_COMPUTE) && (i_q == IDX_LAST) &&
                        (j_q == IDX_LAST) && (k_q == IDX_LAST);
    assign w_tx_done  = (state_q == S_TX) && (tx_cnt_q == TX_LAST);

    // Storage is row-major, LSB first, so the stream bit index is the vector bit index.
    assign w_xsel    = XI_W'((int'(i_q)*N + int'(k_q)) * D_W);
    assign w_ysel    = XI_W'((int'(k_q)*N + int'(j_q)) * D_W);
    assign w_zsel    = ZI_W'((int'(i_q)*N + int'(j_q)) * ACC_W);
    assign w_tx_next = tx_cnt_q + 1'b1;

    assign w_xe   = x_q[w_xsel +: D_W];
    assign w_ye   = y_q[w_ysel +: D_W];
    assign w_xx   = {{(ACC_W-D_W){w_xe[D_W-1] & SIGN_EXT}}, w_xe};
    assign w_yx   = {{(ACC_W-D_W){w_ye[D_W-1] & SIGN_EXT}}, w_ye};
    assign w_prod = w_xx * w_yx;
    assign w_zold = z_q[w_zsel +: ACC_W];
    assign w_base = (k_q == '0) ? (acc_mode_q ? w_zold : '0) : acc_q;
    assign w_sum  = w_base + w_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (w_start)    state_d = S_COMPUTE;
            S_COMPUTE: if (w_mac_last) state_d = S_TX;
            S_TX:      if (w_tx_done)  state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            acc_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            ld_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            loaded_q   <= 1'b0;
            acc_mode_q <= 1'b0;
            dout_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_last_q  <= 1'b0;
        end else begin
            if (w_load) begin
                x_q[ld_cnt_q] <= bus.data_in_x;
                y_q[ld_cnt_q] <= bus.data_in_y;
                if (ld_cnt_q == LD_LAST) begin
                    loaded_q <= 1'b1;
                end else begin
                    ld_cnt_q <= ld_cnt_q + 1'b1;
                end
            end

            if (w_start) begin
                acc_mode_q <= bus.acc_mode;
                i_q        <= '0;
                j_q        <= '0;
                k_q        <= '0;
            end

            if (state_q == S_COMPUTE) begin
                acc_q <= w_sum;
                if (k_q == IDX_LAST) begin
                    z_q[w_zsel +: ACC_W] <= w_sum;
                    k_q <= '0;
                    if (j_q == IDX_LAST) begin
                        j_q <= '0;
                        i_q <= (i_q == IDX_LAST) ? '0 : i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end else begin
                    k_q <= k_q + 1'b1;
                end
                // Bit 0 of Z[0][0] must be on the pin the cycle TX starts; with N=1
                // that element is being written on this very edge.
                if (w_mac_last) begin
                    tx_cnt_q   <= '0;
                    dout_q     <= (w_zsel == '0) ? w_sum[0] : z_q[0];
                    tx_ready_q <= 1'b1;
                    tx_last_q  <= (TX_LAST == '0);
                end
            end

            if (state_q == S_TX) begin
                if (w_tx_done) begin
                    dout_q     <= 1'b0;
                    tx_ready_q <= 1'b0;
                    tx_last_q  <= 1'b0;
                    loaded_q   <= 1'b0;
                    ld_cnt_q   <= '0;
                end else begin
                    tx_cnt_q   <= w_tx_next;
                    dout_q     <= z_q[w_tx_next];
                    tx_last_q  <= (w_tx_next == TX_LAST);
                end
            end
        end
    end

    assign bus.data_out_z = dout_q;
    assign bus.tx_ready   = tx_ready_q;
    assign bus.tx_last    = tx_last_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.loaded     = loaded_q;

endmodule

`default_nettype wire

// File: tb/tb_tinytpu_mmu_serial.sv
// ============================================================================
// tb_tinytpu_mmu_serial
// Directed bench: unsigned and signed instances share stimulus, results decoded from the stream.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tinytpu_mmu_serial;

    logic clk = 1'b0;
    logic rst;
    logic x, y, load_en, init, acc_mode;
    int   checks = 0;
    int   errors = 0;
    logic [71:0] zu, zs;

    tinytpu_mmu_serial_if bus_u ();
    tinytpu_mmu_serial_if bus_s ();

    assign bus_u.data_in_x = x;
    assign bus_u.data_in_y = y;
    assign bus_u.load_en   = load_en;
    assign bus_u.init      = init;
    assign bus_u.acc_mode  = acc_mode;
    assign bus_s.data_in_x = x;
    assign bus_s.data_in_y = y;
    assign bus_s.load_en   = load_en;
    assign bus_s.init      = init;
    assign bus_s.acc_mode  = acc_mode;

    tinytpu_mmu_serial #(.D_W(8), .N(2), .ACC_W(18), .SIGNED(0)) u_dut_u (
        .clk (clk),
        .rst (rst),
        .bus (bus_u)
    );

    tinytpu_mmu_serial #(.D_W(8), .N(2), .ACC_W(18), .SIGNED(1)) u_dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] zpack(input logic [17:0] a, input logic [17:0] b,
                                          input logic [17:0] c, input logic [17:0] d);
        return {d, c, b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Matrices packed row-major, element 0 in the low byte, so stream bit b = vector bit b.
    task automatic load(input logic [31:0] xv, input logic [31:0] yv,
                        input bit gaps, input bit init_last);
        for (int b = 0; b < 32; b++) begin
            if (gaps && (b % 5 == 2)) begin
                load_en = 1'b0;
                x = 1'b1;
                y = 1'b1;
                tick();
            end
            load_en = 1'b1;
            x = xv[b];
            y = yv[b];
            if (init_last && b == 31) begin
                init = 1'b1;
                acc_mode = 1'b0;
            end
            tick();
        end
        load_en = 1'b0;
        init = 1'b0;
        x = 1'b0;
        y = 1'b0;
        check("loaded_after_load", {bus_u.loaded, bus_s.loaded}, 2'b11);
        check("idle_after_load", {bus_u.busy, bus_s.busy}, 2'b00);
    endtask

    task automatic run(input logic acc, input bit pulse,
                       output logic [71:0] ou, output logic [71:0] os);
        int first, nbits, last_cnt, last_at, dz_bad, end_c;
        ou = '0;
        os = '0;
        first = -1;
        nbits = 0;
        last_cnt = 0;
        last_at = -1;
        dz_bad = 0;
        end_c = -1;
        acc_mode = acc;
        init = 1'b1;
        tick();
        init = 1'b0;
        acc_mode = 1'b0;
        check("busy_cycle1", {bus_u.busy, bus_s.busy}, 2'b11);
        for (int c = 1; c <= 150; c++) begin
            if (bus_u.tx_ready) begin
                if (first < 0) first = c;
                if (nbits < 72) begin
                    ou[7'(nbits)] = bus_u.data_out_z;
                    os[7'(nbits)] = bus_s.data_out_z;
                end
                if (bus_u.tx_last) begin
                    last_cnt++;
                    last_at = c;
                end
                nbits++;
            end else begin
                if (bus_u.data_out_z !== 1'b0) dz_bad++;
                if (first >= 0) begin
                    end_c = c;
                    break;
                end
            end
            if (pulse) begin
                load_en = (c >= 2 && c <= 6);
                x = 1'b1;
                y = 1'b1;
            end
            tick();
        end
        load_en = 1'b0;
        x = 1'b0;
        y = 1'b0;
        check("first_bit_cycle", first, 9);
        check("bit_count", nbits, 72);
        check("tx_last_count", last_cnt, 1);
        check("tx_last_cycle", last_at, 80);
        check("end_cycle", end_c, 81);
        check("dout_zero_when_idle", dz_bad, 0);
        check("outputs_after_tx",
              {bus_u.busy, bus_u.tx_ready, bus_u.tx_last, bus_u.loaded,
               bus_s.busy, bus_s.tx_ready, bus_s.tx_last, bus_s.loaded}, 8'h00);
    endtask

    localparam logic [31:0] T1X = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [31:0] T1Y = {8'd8, 8'd7, 8'd6, 8'd5};

    initial begin
        int n;
        rst = 1'b1;
        x = 1'b0;
        y = 1'b0;
        load_en = 1'b0;
        init = 1'b0;
        acc_mode = 1'b0;
        tick();
        tick();
        check("reset_outputs",
              {bus_u.data_out_z, bus_u.tx_ready, bus_u.tx_last, bus_u.busy, bus_u.loaded,
               bus_s.data_out_z, bus_s.tx_ready, bus_s.tx_last, bus_s.busy, bus_s.loaded}, 10'h0);
        rst = 1'b0;
        tick();

        // init without a loaded operand set must not start anything
        init = 1'b1;
        tick();
        init = 1'b0;
        check("init_unloaded_busy", {bus_u.busy, bus_u.loaded}, 2'b00);
        tick();
        tick();
        check("init_unloaded_busy_late", {bus_u.busy, bus_s.busy}, 2'b00);

        // gapped load, init on final bit (ignored), load_en pulses during COMPUTE
        load(T1X, T1Y, 1'b1, 1'b1);
        run(1'b0, 1'b1, zu, zs);
        check("unsigned_product_u", zu, zpack(18'd19, 18'd22, 18'd43, 18'd50));
        check("unsigned_product_s", zs, zpack(18'd19, 18'd22, 18'd43, 18'd50));

        load(T1X, T1Y, 1'b0, 1'b0);
        run(1'b1, 1'b0, zu, zs);
        check("accumulate_u", zu, zpack(18'd38, 18'd44, 18'd86, 18'd100));
        check("accumulate_s", zs, zpack(18'd38, 18'd44, 18'd86, 18'd100));

        load({8'hFF, 8'h00, 8'h00, 8'hFF}, {8'd1, 8'd0, 8'd0, 8'd1}, 1'b0, 1'b0);
        run(1'b0, 1'b0, zu, zs);
        check("neg_identity_s", zs, zpack(18'h3FFFF, 18'd0, 18'd0, 18'h3FFFF));
        check("neg_identity_u", zu, zpack(18'd255, 18'd0, 18'd0, 18'd255));

        load({4{8'h80}}, {4{8'h80}}, 1'b0, 1'b0);
        run(1'b0, 1'b0, zu, zs);
        check("extreme_s", zs, zpack(18'h08000, 18'h08000, 18'h08000, 18'h08000));
        check("extreme_u", zu, zpack(18'h08000, 18'h08000, 18'h08000, 18'h08000));

        // reset asserted while TX bit 10 is on the pin
        load(T1X, T1Y, 1'b0, 1'b0);
        init = 1'b1;
        tick();
        init = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus_u.tx_ready) begin
                if (n == 10) break;
                n++;
            end
            tick();
        end
        check("reached_tx_bit10", {bus_u.tx_ready, 7'(n)}, {1'b1, 7'd10});
        #2 rst = 1'b1;
        #1;
        check("reset_mid_tx",
              {bus_u.data_out_z, bus_u.tx_ready, bus_u.tx_last, bus_u.busy, bus_u.loaded,
               bus_s.data_out_z, bus_s.tx_ready, bus_s.tx_last, bus_s.busy, bus_s.loaded}, 10'h0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("idle_after_reset", {bus_u.tx_ready, bus_u.busy, bus_s.tx_ready, bus_s.busy}, 4'h0);
        load(T1X, T1Y, 1'b0, 1'b0);
        run(1'b1, 1'b0, zu, zs);
        check("acc_after_reset_u", zu, zpack(18'd19, 18'd22, 18'd43, 18'd50));
        check("acc_after_reset_s", zs, zpack(18'd19, 18'd22, 18'd43, 18'd50));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tinytpu_mmu_serial.md
# tinytpu_mmu_serial

Parametrised bit-serial matrix-multiply core; successor to the fixed 2×2 tinytpu core. It accepts two N×N operand matrices X and Y over single-bit serial lanes, computes Z = X·Y with a sequential multiply-accumulate (MAC), and streams Z back out on one serial pin. It adds signed/unsigned arithmetic, accumulate-onto-previous-result mode, and end-of-stream marking. It sits directly under the TinyTapeout top wrapper, on the ui_in/uo_out pins.

## Interface
Parameters:
- D_W, 8, operand element width in bits
- N, 2, matrix dimension (N×N), N ≥ 1
- ACC_W, 2*D_W+$clog2(N)+1, width of each Z element
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- data_in_x  in  1  serial X bit
- data_in_y  in  1  serial Y bit
- load_en  in  1  qualifies data_in_x/data_in_y this cycle
- init  in  1  start-compute request
- acc_mode  in  1  sampled with init: 1 = Z += X·Y, 0 = Z = X·Y
- data_out_z  out  1  serial Z bit, registered
- tx_ready  out  1  high while data_out_z carries a valid bit
- tx_last  out  1  high on the final bit of the Z stream
- busy  out  1  high in COMPUTE or TX
- loaded  out  1  both operand matrices fully received

## Operation
States: IDLE, COMPUTE, TX.

Reset:
- All outputs 0; state = IDLE.
- Bit counters, X/Y/Z storage and acc_mode latch are cleared to 0.

Load (IDLE only):
- Each cycle with load_en=1, one bit per lane is captured.
- Element order is row-major: X[0][0], X[0][1], …; within each element, LSB first.
- Total is N·N·D_W qualified cycles. load_en may drop at any point; the bit counter holds.
- After the final bit, loaded=1 from the next cycle.
- Further load_en bits are ignored while loaded=1 or busy=1.

Transition IDLE→COMPUTE:
- Taken on init=1 with loaded=1. acc_mode is latched in the same cycle.
- init with loaded=0 is ignored, as is init in the same cycle as the final load bit.
- init is ignored outside IDLE.

COMPUTE:
- One MAC per cycle, loop order i, j, k (k innermost), N³ cycles total.
- At k=0 the accumulator is seeded with Z[i][j] if acc_mode=1, else with 0.
- Each product is D_W×D_W, sign-extended (SIGNED=1) or zero-extended to ACC_W.
- Sums wrap modulo 2^ACC_W, with no saturation.
- Z[i][j] is written at k=N−1.

TX:
- Z is sent row-major, LSB first, ACC_W bits per element: N·N·ACC_W cycles.
- tx_ready=1 throughout; tx_last=1 only on the last bit.
- On exit: state=IDLE, loaded=0, load counter=0. Z is retained for accumulate mode.

Reset mid-operation (any state): immediate return to reset values. Z is lost and no further output bits are sent.

## Timing
- Cycle 0 = clk edge sampling init=1 in IDLE with loaded=1.
- busy=1 from cycle 1.
- COMPUTE occupies cycles 1..N³.
- First Z bit (Z[0][0] bit 0) is on data_out_z with tx_ready=1 in cycle N³+1.
- Last bit, with tx_last=1, is in cycle N³+N²·ACC_W.
- busy, tx_ready and tx_last are 0 from cycle N³+N²·ACC_W+1; loaded=0 from the same cycle.
- Defaults (N=2, D_W=8, ACC_W=18): load 32 cycles, COMPUTE 8 cycles, TX 72 cycles.
- loaded rises one cycle after the final qualified load bit.
- data_out_z is 0 whenever tx_ready=0.

## Test plan
- Unsigned product: SIGNED=0, X=[[1,2],[3,4]], Y=[[5,6],[7,8]], init with acc_mode=0 → stream decodes to Z=[[19,22],[43,50]]; tx_last only on bit 72; first bit at cycle 9.
- Signed product: X=[[-1,0],[0,-1]] (8'hFF), Y=identity → Z=[[18'h3FFFF,0],[0,18'h3FFFF]].
- Extreme operands: all elements −128, SIGNED=1 → every Z element = 32768 (18'h08000).
- Accumulate: repeat the unsigned load, then init with acc_mode=1 → Z=[[38,44],[86,100]].
- Ignored inputs: init before load completes → busy stays 0. load_en pulses during COMPUTE → Z unchanged. Load with load_en gaps → same Z as a gap-free load.
- Reset mid-TX: assert rst at TX bit 10 → tx_ready=0, busy=0, loaded=0 immediately. A fresh load plus init with acc_mode=1 gives a plain X·Y result, since Z was cleared.
